// File: rtl/clk_div_cfg_ctrl_pkg.sv
// Shared types and constants for the CLK_div reprogramming sequencer.
// Imported by the controller top and its interface users.
package clk_div_cfg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_GATE,
    ST_LOAD,
    ST_RST,
    ST_ENABLE,
    ST_WAIT_REL
  } state_e;

  // Ratios at or below this value make CLK_div pass the reference clock through.
  localparam int BYPASS_MAX = 1;

  // One counter serves both the GATE hold and the DRAIN timeout.
  function automatic int cnt_width(input int gate_cyc, input int timeout);
    return $clog2(((gate_cyc > timeout) ? gate_cyc : timeout) + 1);
  endfunction

endpackage

// File: rtl/clk_div_cfg_ctrl_if.sv
// Config-side request/ack and divider-side control signals of the sequencer.
// slave = controller, master = config requester plus divider feedback.
interface clk_div_cfg_ctrl_if #(
  parameter int RATIO_WIDTH = 5
);
  logic                   Cfg_Req;
  logic [RATIO_WIDTH-1:0] Cfg_Ratio;
  logic                   Cfg_Ack;
  logic                   Cfg_Busy;
  logic                   Cfg_Err;
  logic                   Locked;
  logic                   Div_Out;
  logic                   Div_En;
  logic [RATIO_WIDTH-1:0] Div_Ratio;
  logic                   Div_Rst_n;

  modport slave (
    input  Cfg_Req, Cfg_Ratio, Div_Out,
    output Cfg_Ack, Cfg_Busy, Cfg_Err, Locked, Div_En, Div_Ratio, Div_Rst_n
  );

  modport master (
    output Cfg_Req, Cfg_Ratio, Div_Out,
    input  Cfg_Ack, Cfg_Busy, Cfg_Err, Locked, Div_En, Div_Ratio, Div_Rst_n
  );
endinterface

// File: rtl/clk_div_cfg_ctrl_neg_edge_det.sv
// Falling-edge detector on the divider output; the previous level is registered
// so the flag is high in the first cycle the divider output is seen low.
module clk_div_cfg_ctrl_neg_edge_det (
  input  logic CLK,
  input  logic Reset,
  input  logic din,
  output logic fall
);
  logic din_q;

  always_ff @(posedge CLK) begin
    if (Reset) din_q <= 1'b0;
    else       din_q <= din;
  end

  assign fall = din_q & ~din;
endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Sequencer that reprograms CLK_div glitch-free: drain to low phase, gate,
// load ratio, pulse divider reset, re-enable. Outputs are registered from next state.
module clk_div_cfg_ctrl
  import clk_div_cfg_ctrl_pkg::*;
#(
  parameter int RATIO_WIDTH   = 5,
  parameter int DEFAULT_RATIO = 1,
  parameter int GATE_CYC      = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic                 CLK,
  input  logic                 Reset,
  clk_div_cfg_ctrl_if.slave    bus
);
  localparam int                     CW        = cnt_width(GATE_CYC, TIMEOUT);
  localparam logic [CW-1:0]          GATE_LD   = CW'(GATE_CYC - 1);
  localparam logic [CW-1:0]          TMO_LD    = CW'(TIMEOUT - 1);
  localparam logic [RATIO_WIDTH-1:0] DEF_R     = RATIO_WIDTH'(DEFAULT_RATIO);
  localparam logic [RATIO_WIDTH-1:0] BYPASS_R  = RATIO_WIDTH'(BYPASS_MAX);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RATIO_WIDTH-1:0] shadow_q, shadow_d;
  logic                   pu_q, pu_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   div_en_q, div_rst_n_q, ack_q, locked_q;
  logic [RATIO_WIDTH-1:0] div_ratio_q;
  logic                   div_fall;

  clk_div_cfg_ctrl_neg_edge_det u_fall (
    .CLK   (CLK),
    .Reset (Reset),
    .din   (bus.Div_Out),
    .fall  (div_fall)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    pu_d     = pu_q;
    busy_d   = busy_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Cfg_Req) begin
          shadow_d = bus.Cfg_Ratio;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          // Same ratio already running: acknowledge without touching the divider.
          if (bus.Cfg_Ratio == div_ratio_q && locked_q) begin
            state_d = ST_ENABLE;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = TMO_LD;
          end
        end
      end
      ST_DRAIN: begin
        if (div_ratio_q <= BYPASS_R || div_fall) begin
          state_d = ST_GATE;
          cnt_d   = GATE_LD;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_GATE;
          cnt_d   = GATE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GATE: begin
        if (cnt_q == '0) state_d = ST_LOAD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_LOAD: state_d = ST_RST;
      ST_RST:  state_d = ST_ENABLE;
      ST_ENABLE: begin
        if (pu_q) begin
          state_d = ST_IDLE;
          pu_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!bus.Cfg_Req) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_GATE;
      cnt_q       <= GATE_LD;
      shadow_q    <= DEF_R;
      pu_q        <= 1'b1;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      div_en_q    <= 1'b0;
      div_ratio_q <= DEF_R;
      div_rst_n_q <= 1'b1;
      ack_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      pu_q        <= pu_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      div_rst_n_q <= (state_d != ST_RST);
      ack_q       <= (state_d == ST_ENABLE) && !pu_q;
      if (state_d == ST_LOAD) div_ratio_q <= shadow_q;
      if (state_d == ST_GATE) begin
        div_en_q <= 1'b0;
        locked_q <= 1'b0;
      end else if (state_d == ST_ENABLE) begin
        div_en_q <= 1'b1;
        locked_q <= 1'b1;
      end
    end
  end

  assign bus.Cfg_Ack   = ack_q;
  assign bus.Cfg_Busy  = busy_q;
  assign bus.Cfg_Err   = err_q;
  assign bus.Locked    = locked_q;
  assign bus.Div_En    = div_en_q;
  assign bus.Div_Ratio = div_ratio_q;
  assign bus.Div_Rst_n = div_rst_n_q;
endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Bench for clk_div_cfg_ctrl: a simple CLK_div model closes the Div_Out loop,
// and expected latencies/ratios come from a request-level model of the sequence.
module tb_clk_div_cfg_ctrl;
  localparam int RW = 5, DEF = 1, GATE_CYC = 2, TIMEOUT = 64;
  localparam logic [10:0] RST_EXP = {1'b0, RW'(DEF), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  clk_div_cfg_ctrl_if #(.RATIO_WIDTH(RW)) bus();

  clk_div_cfg_ctrl #(.RATIO_WIDTH(RW), .DEFAULT_RATIO(DEF), .GATE_CYC(GATE_CYC), .TIMEOUT(TIMEOUT))
    dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  always #5 CLK = ~CLK;

  // CLK_div stand-in: high for ratio/2 of every ratio cycles; bypass ratios idle low.
  logic [RW-1:0] dcnt = '0;
  logic [RW-1:0] dnxt;
  logic          dout = 1'b0;
  bit            tie_low = 1'b0;
  always_comb dnxt = (int'(dcnt) + 1 >= int'(bus.Div_Ratio)) ? '0 : dcnt + 1'b1;
  always @(posedge CLK) begin
    if (!bus.Div_Rst_n) begin
      dcnt <= '0;
      dout <= 1'b0;
    end else if (bus.Div_En && bus.Div_Ratio > RW'(1)) begin
      dcnt <= dnxt;
      dout <= (dnxt < (bus.Div_Ratio >> 1));
    end
  end
  assign bus.Div_Out = tie_low ? 1'b0 : dout;

  int total = 0, bad = 0;
  int m_ratio;
  bit m_locked;

  function automatic logic [10:0] out_vec();
    return {bus.Div_En, bus.Div_Ratio, bus.Div_Rst_n, bus.Cfg_Ack, bus.Cfg_Busy, bus.Cfg_Err, bus.Locked};
  endfunction

  // Issues one request, scrambles Cfg_Ratio after acceptance, drops Req on Ack.
  task automatic run_req(input int r, output int lat, output int n_ack, output int en_low,
                         output int en_first_dout, output int busy_end, output int err_ack,
                         output int ratio_ack);
    for (int w = 0; w < 20 && bus.Cfg_Busy; w++) @(negedge CLK);
    @(negedge CLK);
    bus.Cfg_Req = 1'b1;
    bus.Cfg_Ratio = RW'(r);
    lat = -1; n_ack = 0; en_low = 0; en_first_dout = -1; err_ack = -1; ratio_ack = -1;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(posedge CLK); #1;
      bus.Cfg_Ratio = RW'($urandom);
      if (!bus.Div_En) begin
        if (en_low == 0) en_first_dout = int'(bus.Div_Out);
        en_low++;
      end
      if (bus.Cfg_Ack) begin
        lat = k; n_ack++;
        err_ack = int'(bus.Cfg_Err);
        ratio_ack = int'(bus.Div_Ratio);
      end
    end
    bus.Cfg_Req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      if (bus.Cfg_Ack) n_ack++;
    end
    busy_end = int'(bus.Cfg_Busy);
  endtask

  task automatic test_reset();
    logic [8:0] mask, exp_mask;
    int acks = 0, busy5 = -1, ratio8 = -1;
    logic [1:0] en4 = '0;
    bus.Cfg_Req = 1'b1; bus.Cfg_Ratio = RW'(9); Reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (out_vec() !== RST_EXP) begin bad++; $display("FAIL reset_vals: got %h want %h", out_vec(), RST_EXP); end
    @(negedge CLK); Reset = 1'b0; bus.Cfg_Req = 1'b0;
    mask = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      mask[k] = !bus.Div_Rst_n;
      if (bus.Cfg_Ack) acks++;
      if (k == 4) en4 = {bus.Div_En, bus.Locked};
      if (k == 5) busy5 = int'(bus.Cfg_Busy);
      if (k == 8) ratio8 = int'(bus.Div_Ratio);
    end
    exp_mask = 9'b0_0000_1000;  // divider reset only in cycle GATE_CYC+1 after release
    total++; if (mask !== exp_mask) begin bad++; $display("FAIL pu_rst_pulse: got %b want %b", mask, exp_mask); end
    total++; if (en4 !== 2'b11) begin bad++; $display("FAIL pu_en_locked: got %b want 11", en4); end
    total++; if (acks !== 0) begin bad++; $display("FAIL pu_no_ack: got %0d want 0", acks); end
    total++; if (busy5 !== 0) begin bad++; $display("FAIL pu_busy: got %0d want 0", busy5); end
    total++; if (ratio8 !== DEF) begin bad++; $display("FAIL pu_ratio: got %0d want %0d", ratio8, DEF); end
    m_ratio = DEF; m_locked = 1'b1;
  endtask

  task automatic test_bypass_ratio4();
    int lat, na, el, efd, be, ea, ra, r1 = -1, r2 = -1;
    logic prev;
    run_req(4, lat, na, el, efd, be, ea, ra);
    total++; if (lat !== 4 + GATE_CYC) begin bad++; $display("FAIL r4_latency: got %0d want %0d", lat, 4 + GATE_CYC); end
    total++; if (el !== GATE_CYC + 2) begin bad++; $display("FAIL r4_en_low: got %0d want %0d", el, GATE_CYC + 2); end
    total++; if (ra !== 4) begin bad++; $display("FAIL r4_ratio: got %0d want 4", ra); end
    total++; if (na !== 1) begin bad++; $display("FAIL r4_acks: got %0d want 1", na); end
    total++; if (be !== 0) begin bad++; $display("FAIL r4_busy_end: got %0d want 0", be); end
    prev = bus.Div_Out;
    for (int k = 0; k < 40 && r2 < 0; k++) begin
      @(posedge CLK); #1;
      if (!prev && bus.Div_Out) begin
        if (r1 < 0) r1 = k; else r2 = k;
      end
      prev = bus.Div_Out;
    end
    total++; if ((r2 - r1) * 10 !== 40 || r1 < 0) begin bad++; $display("FAIL r4_period_ns: got %0d want 40", (r2 - r1) * 10); end
    m_ratio = 4;
  endtask

  task automatic test_drain_ratio7();
    int lat, na, el, efd, be, ea, ra, prev_r;
    prev_r = m_ratio;
    run_req(7, lat, na, el, efd, be, ea, ra);
    total++; if (efd !== 0) begin bad++; $display("FAIL r7_gate_in_low_phase: got %0d want 0", efd); end
    total++; if (lat < 4 + GATE_CYC || lat > prev_r + 3 + GATE_CYC) begin bad++; $display("FAIL r7_latency: got %0d want %0d..%0d", lat, 4 + GATE_CYC, prev_r + 3 + GATE_CYC); end
    total++; if (ra !== 7) begin bad++; $display("FAIL r7_ratio: got %0d want 7", ra); end
    total++; if (ea !== 0) begin bad++; $display("FAIL r7_err: got %0d want 0", ea); end
    m_ratio = 7;
  endtask

  task automatic test_same_ratio();
    int lat, na, el, efd, be, ea, ra;
    run_req(m_ratio, lat, na, el, efd, be, ea, ra);
    total++; if (lat !== 1) begin bad++; $display("FAIL same_latency: got %0d want 1", lat); end
    total++; if (el !== 0) begin bad++; $display("FAIL same_en_drop: got %0d want 0", el); end
    total++; if (na !== 1) begin bad++; $display("FAIL same_acks: got %0d want 1", na); end
  endtask

  task automatic test_timeout();
    int lat, na, el, efd, be, ea, ra;
    run_req(10, lat, na, el, efd, be, ea, ra);
    total++; if (ra !== 10) begin bad++; $display("FAIL to_pre_ratio: got %0d want 10", ra); end
    tie_low = 1'b1;
    repeat (3) @(posedge CLK);
    run_req(5, lat, na, el, efd, be, ea, ra);
    total++; if (ea !== 1) begin bad++; $display("FAIL to_err: got %0d want 1", ea); end
    total++; if (lat !== TIMEOUT + GATE_CYC + 3) begin bad++; $display("FAIL to_latency: got %0d want %0d", lat, TIMEOUT + GATE_CYC + 3); end
    total++; if (ra !== 5) begin bad++; $display("FAIL to_ratio: got %0d want 5", ra); end
    total++; if (na !== 1) begin bad++; $display("FAIL to_acks: got %0d want 1", na); end
    tie_low = 1'b0;
    run_req(5, lat, na, el, efd, be, ea, ra);
    total++; if (ea !== 0) begin bad++; $display("FAIL to_err_clear: got %0d want 0", ea); end
    m_ratio = 5;
  endtask

  task automatic test_random();
    int r, prev_r, lat, na, el, efd, be, ea, ra;
    for (int i = 0; i < 12; i++) begin
      r = ($urandom_range(0, 3) == 0) ? m_ratio : int'($urandom_range(0, 31));
      prev_r = m_ratio;
      run_req(r, lat, na, el, efd, be, ea, ra);
      if (r == prev_r && m_locked) begin
        total++; if (lat !== 1 || el !== 0) begin bad++; $display("FAIL rnd%0d_same: lat %0d en_low %0d want 1 0", i, lat, el); end
      end else if (prev_r <= 1) begin
        total++; if (lat !== 4 + GATE_CYC || el !== GATE_CYC + 2) begin bad++; $display("FAIL rnd%0d_bypass: lat %0d en_low %0d want %0d %0d", i, lat, el, 4 + GATE_CYC, GATE_CYC + 2); end
      end else begin
        total++; if (lat < 4 + GATE_CYC || lat > prev_r + 3 + GATE_CYC || el !== GATE_CYC + 2) begin bad++; $display("FAIL rnd%0d_drain: lat %0d en_low %0d want %0d..%0d %0d", i, lat, el, 4 + GATE_CYC, prev_r + 3 + GATE_CYC, GATE_CYC + 2); end
        if (prev_r >= 3) begin
          total++; if (efd !== 0) begin bad++; $display("FAIL rnd%0d_runt: got %0d want 0", i, efd); end
        end
      end
      total++; if (ra !== r) begin bad++; $display("FAIL rnd%0d_ratio: got %0d want %0d", i, ra, r); end
      total++; if (na !== 1 || ea !== 0 || be !== 0) begin bad++; $display("FAIL rnd%0d_hs: acks %0d err %0d busy %0d want 1 0 0", i, na, ea, be); end
      m_ratio = r;
    end
  endtask

  task automatic test_reset_mid();
    int r, lat = -1, acks = 0, busy_low = 0, ra = -1;
    bit seen = 1'b0;
    r = (m_ratio == 9) ? 12 : 9;
    @(negedge CLK);
    bus.Cfg_Req = 1'b1; bus.Cfg_Ratio = RW'(r);
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge CLK); #1;
      if (!bus.Div_En) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL mid_gate_reached: got %0d want 1", seen); end
    Reset = 1'b1;
    @(posedge CLK); #1;
    total++; if (out_vec() !== RST_EXP) begin bad++; $display("FAIL mid_reset_vals: got %h want %h", out_vec(), RST_EXP); end
    @(negedge CLK); Reset = 1'b0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge CLK); #1;
      if (bus.Cfg_Ack) begin lat = k; acks++; ra = int'(bus.Div_Ratio); end
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      if (bus.Cfg_Ack) acks++;
      if (!bus.Cfg_Busy) busy_low++;
    end
    // power-up reaches IDLE at GATE_CYC+3, then a bypass-path request
    total++; if (lat !== (GATE_CYC + 3) + (4 + GATE_CYC)) begin bad++; $display("FAIL mid_latency: got %0d want %0d", lat, 2 * GATE_CYC + 7); end
    total++; if (acks !== 1) begin bad++; $display("FAIL mid_single_ack: got %0d want 1", acks); end
    total++; if (ra !== r) begin bad++; $display("FAIL mid_ratio: got %0d want %0d", ra, r); end
    total++; if (busy_low !== 0) begin bad++; $display("FAIL mid_busy_held: got %0d want 0", busy_low); end
    bus.Cfg_Req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (bus.Cfg_Busy !== 1'b0) begin bad++; $display("FAIL mid_busy_release: got %0d want 0", bus.Cfg_Busy); end
    m_ratio = r;
  endtask

  initial begin
    bus.Cfg_Req = 1'b0;
    bus.Cfg_Ratio = '0;
    test_reset();
    test_bypass_ratio4();
    test_drain_ratio7();
    test_same_ratio();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
